// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and width helpers for the fifo write-port arbiter
package fifo_arb_pkg;

    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} arb_state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational first-requester search starting at a rotating index
module rr_priority_pick #(
    parameter int N   = 2,
    parameter int IDW = 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] start,
    output logic [N-1:0]   pick,
    output logic [IDW-1:0] pick_id,
    output logic           found
);

    logic [IDW-1:0] idx;

    always_comb begin
        pick    = '0;
        pick_id = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = IDW'((int'(start) + i) % N);
            if (!found && req[idx]) begin
                found   = 1'b1;
                pick_id = idx;
            end
        end
        pick[pick_id] = found;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin, burst-limited arbiter driving the fifo write port
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [NUM_REQ-1:0]                   req,
    input  logic [NUM_REQ-1:0][2*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                   gnt,
    input  logic                                 fifo_full,
    output logic                                 fifo_wr,
    output logic [2*DATA_WIDTH-1:0]              fifo_w_data,
    output logic                                 owner_valid,
    output logic [$clog2(NUM_REQ)-1:0]           owner_id
);

    localparam int IDW  = id_width(NUM_REQ);
    localparam int CNTW = cnt_width(BURST_MAX);
    localparam logic [CNTW-1:0] BURST_LIM = CNTW'(BURST_MAX);
    localparam logic [IDW-1:0]  LAST_ID   = IDW'(NUM_REQ - 1);

    arb_state_e         state, state_n;
    logic [IDW-1:0]     owner, owner_n, rr_ptr, rr_ptr_n;
    logic [IDW-1:0]     start_id, pick_id, win_id;
    logic [CNTW-1:0]    burst_cnt, burst_n;
    logic [NUM_REQ-1:0] pick_oh, owner_oh;
    logic               out_valid, cap, found, owner_keep, others_req;

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        return (id == LAST_ID) ? '0 : id + 1'b1;
    endfunction

    assign fifo_wr = out_valid & ~fifo_full;
    // Reset gates capture so gnt is low for the whole reset window, not just after the first edge.
    assign cap = reset_n & found & (~out_valid | fifo_wr);

    assign owner_oh   = NUM_REQ'(1) << owner;
    assign others_req = |(req & ~owner_oh);
    assign owner_keep = (state == OWN) && req[owner] && ((burst_cnt < BURST_LIM) || !others_req);
    assign start_id   = (state == OWN) ? next_id(owner) : rr_ptr;

    rr_priority_pick #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_pick (
        .req     (req),
        .start   (start_id),
        .pick    (pick_oh),
        .pick_id (pick_id),
        .found   (found)
    );

    assign win_id      = owner_keep ? owner : pick_id;
    assign gnt         = cap ? (owner_keep ? owner_oh : pick_oh) : '0;
    assign owner_valid = (state == OWN);
    assign owner_id    = owner;

    always_comb begin
        state_n  = state;
        owner_n  = owner;
        rr_ptr_n = rr_ptr;
        burst_n  = burst_cnt;
        if (cap) begin
            if (state == IDLE) begin
                state_n = OWN;
                owner_n = win_id;
                burst_n = CNTW'(1);
            end else if (owner_keep) begin
                if (burst_cnt < BURST_LIM) burst_n = burst_cnt + 1'b1;
            end else begin
                owner_n  = win_id;
                burst_n  = CNTW'(1);
                rr_ptr_n = next_id(win_id);
            end
        end else if ((state == OWN) && !(|req) && !(out_valid && !fifo_wr)) begin
            state_n  = IDLE;
            rr_ptr_n = next_id(owner);
            burst_n  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            rr_ptr    <= rr_ptr_n;
            burst_cnt <= burst_n;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            fifo_w_data <= '0;
        end else if (cap) begin
            out_valid   <= 1'b1;
            fifo_w_data <= req_data[win_id];
        end else if (fifo_wr) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter with a transaction-level model
module tb_fifo_wr_arbiter;

    localparam int N = 2, DW = 8, BM = 4, WW = 2 * DW, IDW = 1, FIFO_BYTES = 8;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [N-1:0]         req;
    logic [N-1:0][WW-1:0] req_data;
    logic [N-1:0]         gnt;
    logic                 fifo_full;
    logic                 fifo_wr;
    logic [WW-1:0]        fifo_w_data;
    logic                 owner_valid;
    logic [IDW-1:0]       owner_id;

    int total = 0, bad = 0, cyc = 0;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .fifo_full   (fifo_full),
        .fifo_wr     (fifo_wr),
        .fifo_w_data (fifo_w_data),
        .owner_valid (owner_valid),
        .owner_id    (owner_id)
    );

    always #5 clk = ~clk;

    // Environment: producer word queues and a byte-wide fifo fed by the DUT.
    logic [WW-1:0] pend_q [N][$];
    logic [7:0]    fq[$];
    logic [7:0]    rd_log[$];
    int            rd_n = 0;

    // Model: pending output word, current owner, rotation pointer, consecutive-grant run length.
    bit            m_valid = 0, m_locked = 0;
    logic [WW-1:0] m_word = '0;
    int            m_owner = 0, m_ptr = 0, m_run = 0;
    logic [N-1:0]  e_gnt;
    bit            e_wr;
    int            e_win;

    function automatic void model_eval();
        int start, idx, others;
        e_wr  = m_valid && !fifo_full;
        e_win = -1;
        if (req != '0 && (!m_valid || e_wr)) begin
            others = $countones(req) - int'(req[m_owner]);
            if (m_locked && req[m_owner] && (m_run < BM || others == 0)) begin
                e_win = m_owner;
            end else begin
                start = m_locked ? (m_owner + 1) % N : m_ptr;
                for (int k = 0; k < N; k++) begin
                    idx = (start + k) % N;
                    if (e_win < 0 && req[idx]) e_win = idx;
                end
            end
        end
        e_gnt = (e_win >= 0) ? (N'(1) << e_win) : '0;
    endfunction

    function automatic void model_step();
        if (e_win >= 0) begin
            if (!m_locked) begin
                m_locked = 1; m_owner = e_win; m_run = 1;
            end else if (e_win == m_owner) begin
                m_run = (m_run < BM) ? m_run + 1 : BM;
            end else begin
                m_owner = e_win; m_run = 1; m_ptr = (e_win + 1) % N;
            end
            m_word  = req_data[e_win];
            m_valid = 1;
        end else if (e_wr) begin
            m_valid = 0;
        end
        if (m_locked && req == '0 && !m_valid) begin
            m_locked = 0;
            m_ptr    = (m_owner + 1) % N;
        end
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req[i]      = pend_q[i].size() > 0;
            req_data[i] = req[i] ? pend_q[i][0] : '0;
        end
        fifo_full = fq.size() > FIFO_BYTES - 2;
        model_eval();
    endtask

    task automatic advance();
        logic          s_wr;
        logic [WW-1:0] s_data;
        s_wr   = fifo_wr;
        s_data = fifo_w_data;
        @(posedge clk);
        #1;
        for (int k = 0; k < rd_n; k++) if (fq.size() > 0) rd_log.push_back(fq.pop_front());
        if (s_wr) begin
            fq.push_back(s_data[7:0]);
            fq.push_back(s_data[15:8]);
        end
        for (int i = 0; i < N; i++) if (e_gnt[i]) void'(pend_q[i].pop_front());
        model_step();
        cyc++;
        drive_inputs();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int i = 0; i < N; i++) pend_q[i].delete();
        fq.delete();
        rd_log.delete();
        rd_n = 0;
        m_valid = 0; m_locked = 0; m_owner = 0; m_ptr = 0; m_run = 0; m_word = '0;
        drive_inputs();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        drive_inputs();
    endtask

    task automatic test_reset();
        drive_inputs();
        @(negedge clk);
        total++;
        if (gnt !== '0 || fifo_wr !== 1'b0 || fifo_w_data !== '0 || owner_valid !== 1'b0 || owner_id !== '0) begin
            bad++;
            $display("FAIL reset_state gnt=%b wr=%b data=%h ov=%b oid=%0d required all zero", gnt, fifo_wr, fifo_w_data, owner_valid, owner_id);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        pend_q[0].push_back(16'h1234);
        pend_q[0].push_back(16'h5678);
        pend_q[0].push_back(16'h9abc);
        drive_inputs();
        repeat (2) begin
            @(negedge clk);
            total++;
            if (gnt !== e_gnt || fifo_wr !== e_wr || owner_valid !== m_locked || (e_wr && fifo_w_data !== m_word)) begin
                bad++;
                $display("FAIL reset_prerun cyc=%0d gnt=%b/%b wr=%b/%b data=%h/%h", cyc, gnt, e_gnt, fifo_wr, e_wr, fifo_w_data, m_word);
            end
            advance();
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (gnt !== '0 || fifo_wr !== 1'b0 || fifo_w_data !== '0 || owner_valid !== 1'b0 || owner_id !== '0) begin
            bad++;
            $display("FAIL reset_midstream gnt=%b wr=%b data=%h ov=%b oid=%0d required all zero", gnt, fifo_wr, fifo_w_data, owner_valid, owner_id);
        end
        do_reset();
        repeat (4) begin
            @(negedge clk);
            total++;
            if (fifo_wr !== 1'b0) begin
                bad++;
                $display("FAIL reset_no_write cyc=%0d wr=%b required 0", cyc, fifo_wr);
            end
            advance();
        end
    endtask

    task automatic test_single();
        int n_gnt = 0;
        do_reset();
        rd_n = 2;
        pend_q[0].push_back(16'hbeef);
        pend_q[0].push_back(16'hdaad);
        drive_inputs();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (gnt === 2'b01) n_gnt++;
            total++;
            if (gnt !== e_gnt || fifo_wr !== e_wr || owner_valid !== m_locked || (e_wr && fifo_w_data !== m_word)) begin
                bad++;
                $display("FAIL single cyc=%0d gnt=%b/%b wr=%b/%b data=%h/%h", cyc, gnt, e_gnt, fifo_wr, e_wr, fifo_w_data, m_word);
            end
            total++;
            if (fifo_wr !== (c == 1 || c == 2)) begin
                bad++;
                $display("FAIL single_latency c=%0d wr=%b required %b", c, fifo_wr, (c == 1 || c == 2));
            end
            advance();
        end
        total++;
        if (n_gnt != 2) begin
            bad++;
            $display("FAIL single_gnt_count got=%0d required 2", n_gnt);
        end
        total++;
        if (rd_log.size() != 4 || rd_log[0] !== 8'hef || rd_log[1] !== 8'hbe || rd_log[2] !== 8'had || rd_log[3] !== 8'hda) begin
            bad++;
            $display("FAIL single_bytes got=%p required ef be ad da", rd_log);
        end
    endtask

    task automatic test_contention();
        int gi, want;
        do_reset();
        rd_n = 2;
        for (int k = 0; k < 14; k++) begin
            pend_q[0].push_back(WW'($urandom));
            pend_q[1].push_back(WW'($urandom));
        end
        drive_inputs();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            gi   = (gnt === 2'b01) ? 0 : (gnt === 2'b10) ? 1 : -1;
            want = (c / BM) % 2;
            total++;
            if (gi != want) begin
                bad++;
                $display("FAIL contention_seq c=%0d gnt_idx=%0d required %0d", c, gi, want);
            end
            total++;
            if (gnt !== e_gnt || fifo_wr !== e_wr || (e_wr && fifo_w_data !== m_word) || owner_id !== IDW'(m_owner)) begin
                bad++;
                $display("FAIL contention cyc=%0d gnt=%b/%b wr=%b/%b data=%h/%h oid=%0d/%0d", cyc, gnt, e_gnt, fifo_wr, e_wr, fifo_w_data, m_word, owner_id, m_owner);
            end
            advance();
        end
    endtask

    task automatic test_full_stall();
        logic [WW-1:0] w[8];
        int n_wr = 0;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            w[k] = WW'($urandom);
            pend_q[1].push_back(w[k]);
        end
        drive_inputs();
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            total++;
            if (gnt !== e_gnt || fifo_wr !== e_wr || (e_wr && fifo_w_data !== m_word)) begin
                bad++;
                $display("FAIL full_model cyc=%0d gnt=%b/%b wr=%b/%b data=%h/%h", cyc, gnt, e_gnt, fifo_wr, e_wr, fifo_w_data, m_word);
            end
            if (c >= 5 && c <= 10) begin
                total++;
                if (gnt !== '0 || fifo_wr !== 1'b0) begin
                    bad++;
                    $display("FAIL full_stall c=%0d gnt=%b wr=%b required 00 0", c, gnt, fifo_wr);
                end
            end
            if (c >= 11 && fifo_wr === 1'b1) n_wr++;
            rd_n = (c == 10) ? 2 : 0;
            advance();
        end
        total++;
        if (n_wr != 1) begin
            bad++;
            $display("FAIL full_resume writes=%0d required 1", n_wr);
        end
        total++;
        if (fq.size() != 8 || fq[6] !== w[4][7:0] || fq[7] !== w[4][15:8]) begin
            bad++;
            $display("FAIL full_held_word size=%0d tail=%h%h required %h", fq.size(), fq[7], fq[6], w[4]);
        end
    endtask

    task automatic test_handover();
        do_reset();
        rd_n = 2;
        for (int k = 0; k < 2; k++) pend_q[0].push_back(WW'($urandom));
        for (int k = 0; k < 4; k++) pend_q[1].push_back(WW'($urandom));
        drive_inputs();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++;
            if (gnt === '0) begin
                bad++;
                $display("FAIL handover_bubble c=%0d gnt=%b required nonzero", c, gnt);
            end
            if (c == 2) begin
                total++;
                if (gnt !== 2'b10) begin
                    bad++;
                    $display("FAIL handover_gnt gnt=%b required 10", gnt);
                end
            end
            if (c == 3) begin
                total++;
                if (owner_id !== 1'b1 || owner_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL handover_owner oid=%0d ov=%b required 1 1", owner_id, owner_valid);
                end
            end
            total++;
            if (gnt !== e_gnt || fifo_wr !== e_wr || (e_wr && fifo_w_data !== m_word)) begin
                bad++;
                $display("FAIL handover cyc=%0d gnt=%b/%b wr=%b/%b data=%h/%h", cyc, gnt, e_gnt, fifo_wr, e_wr, fifo_w_data, m_word);
            end
            advance();
        end
    endtask

    task automatic test_idle_return();
        do_reset();
        rd_n = 2;
        pend_q[0].push_back(WW'($urandom));
        drive_inputs();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (gnt !== e_gnt || fifo_wr !== e_wr || owner_valid !== m_locked) begin
                bad++;
                $display("FAIL idle_model cyc=%0d gnt=%b/%b wr=%b/%b ov=%b/%b", cyc, gnt, e_gnt, fifo_wr, e_wr, owner_valid, m_locked);
            end
            if (c == 2) begin
                total++;
                if (owner_valid !== 1'b0 || fifo_wr !== 1'b0) begin
                    bad++;
                    $display("FAIL idle_state ov=%b wr=%b required 0 0", owner_valid, fifo_wr);
                end
            end
            advance();
        end
        pend_q[0].push_back(WW'($urandom));
        pend_q[1].push_back(WW'($urandom));
        drive_inputs();
        @(negedge clk);
        total++;
        if (gnt !== 2'b10) begin
            bad++;
            $display("FAIL idle_rr_ptr gnt=%b required 10", gnt);
        end
        advance();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (pend_q[i].size() == 0 && $urandom_range(0, 1) == 1)
                    repeat ($urandom_range(1, 6)) pend_q[i].push_back(WW'($urandom));
            rd_n = (c % 64 < 16) ? 0 : $urandom_range(0, 2);
            drive_inputs();
            @(negedge clk);
            total++;
            if (gnt !== e_gnt || fifo_wr !== e_wr || owner_valid !== m_locked ||
                (e_wr && fifo_w_data !== m_word) || (m_locked && owner_id !== IDW'(m_owner))) begin
                bad++;
                $display("FAIL random cyc=%0d gnt=%b/%b wr=%b/%b data=%h/%h ov=%b/%b oid=%0d/%0d", cyc, gnt, e_gnt,
                         fifo_wr, e_wr, fifo_w_data, m_word, owner_valid, m_locked, owner_id, m_owner);
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_full_stall();
        test_handover();
        test_idle_return();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
